// File: rtl/shift_issue_stage_if.sv
// shift_issue_stage_if: decoded-beat input and shifter-operand output handshake bundle
interface shift_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sh_a;
  logic [31:0] sh_b;
  logic [1:0]  sh_op;
  logic [4:0]  sh_rd;
  logic [15:0] drop_cnt;
  modport master (
    output in_valid, instr, rs_data, rt_data, out_ready,
    input  in_ready, out_valid, sh_a, sh_b, sh_op, sh_rd, drop_cnt
  );
  modport slave (
    input  in_valid, instr, rs_data, rt_data, out_ready,
    output in_ready, out_valid, sh_a, sh_b, sh_op, sh_rd, drop_cnt
  );
endinterface

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: decodes MIPS shifts into shifter operands behind a 2-entry skid buffer
module shift_issue_stage (
  input logic             clk,
  input logic             rst_n,
  input logic             flush,
  shift_issue_stage_if.slave bus
);
  typedef struct packed {
    logic [31:0] a;
    logic [4:0]  amt;
    logic [1:0]  op;
    logic [4:0]  rd;
  } beat_t;
  beat_t or_q, sr_q, nb;
  logic or_v, sr_v, is_shift, acc, fwd, drop, pop;
  logic [5:0] funct;
  logic [15:0] drop_q;
  logic unused;
  assign unused = ^{bus.instr[25:16], bus.rs_data[31:5]};
  // Shift functs are 000xyy with yy != 01; funct[2] picks the register-sourced amount
  always_comb begin
    funct = bus.instr[5:0];
    is_shift = bus.instr[31:26] == 6'd0 && funct[5:3] == 3'd0 && funct[1:0] != 2'b01;
    nb.a = bus.rt_data;
    nb.amt = funct[2] ? bus.rs_data[4:0] : bus.instr[10:6];
    nb.op = {funct[1] & funct[0], funct[1]};
    nb.rd = bus.instr[15:11];
    acc = bus.in_valid && bus.in_ready;
    fwd = acc && is_shift;
    drop = acc && !is_shift;
    pop = or_v && bus.out_ready;
  end
  // in_ready is !sr_v, so a new beat never arrives while SR is occupied
  always_ff @(posedge clk)
    if (!rst_n) begin
      or_v <= 1'b0;
      sr_v <= 1'b0;
      or_q <= '0;
      sr_q <= '0;
      drop_q <= '0;
    end else begin
      if (drop && !flush && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (flush) begin
        or_v <= 1'b0;
        sr_v <= 1'b0;
      end else if (!or_v || pop) begin
        or_v <= sr_v || fwd;
        if (sr_v || fwd) or_q <= sr_v ? sr_q : nb;
        sr_v <= 1'b0;
      end else if (fwd) begin
        sr_v <= 1'b1;
        sr_q <= nb;
      end
    end
  assign bus.in_ready = !sr_v;
  assign bus.out_valid = or_v;
  assign bus.sh_a = or_q.a;
  assign bus.sh_b = {21'd0, or_q.amt, 6'd0};
  assign bus.sh_op = or_q.op;
  assign bus.sh_rd = or_q.rd;
  assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: directed vectors with a scoreboard queue and an independent output monitor
module tb_shift_issue_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;
  shift_issue_stage_if bus();
  shift_issue_stage dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
  logic [70:0] q[$];
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && bus.out_valid) begin
      if (q.size() == 0) chk("spurious_out_valid", bus.out_valid, 0);
      else if (bus.out_ready) chk("beat", {bus.sh_a, bus.sh_b, bus.sh_op, bus.sh_rd}, q.pop_front());
    end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                      input bit fw, input logic [31:0] b, input logic [1:0] op, input logic [4:0] rd);
    int t = 0;
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.instr = ins;
    bus.rs_data = rs;
    bus.rt_data = rt;
    while (!ok && t < 20) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) chk("accept_timeout", ok, 1);
    else if (fw) q.push_back({rt, b, op, rd});
    bus.in_valid = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_sh_a"}, bus.sh_a, 0);
    chk({tag, "_sh_b"}, bus.sh_b, 0);
    chk({tag, "_sh_op"}, bus.sh_op, 0);
    chk({tag, "_sh_rd"}, bus.sh_rd, 0);
    chk({tag, "_drop_cnt"}, bus.drop_cnt, 0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.instr = '0;
    bus.rs_data = '0;
    bus.rt_data = '0;
    bus.out_ready = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    chk_reset("rst");
    bus.out_ready = 1'b1;
    send(32'h00021902, 32'h0, 32'hF0000000, 1, 32'h100, 2'b01, 5'd3);
    chk("latency_out_valid", bus.out_valid, 1);
    send(32'h00E62807, 32'h25, 32'h80000000, 1, 32'h140, 2'b11, 5'd5);
    send(32'h00222004, 32'h3F, 32'h12345678, 1, 32'h7C0, 2'b00, 5'd4);
    send(32'h00223006, 32'h10, 32'hCAFEBABE, 1, 32'h400, 2'b01, 5'd6);
    send(32'h00023FC3, 32'hFFFFFFFF, 32'h87654321, 1, 32'h7C0, 2'b11, 5'd7);
    send(32'h00000000, 32'h1F, 32'hDEADBEEF, 1, 32'h0, 2'b00, 5'd0);
    cyc(2);
    chk("stream_drained", q.size(), 0);
    chk("idle_out_valid", bus.out_valid, 0);
    send(32'h00430820, 32'h7, 32'h9, 0, 0, 0, 0);
    chk("drop_cnt_1", bus.drop_cnt, 1);
    send(32'h20000000, 32'h0, 32'h0, 0, 0, 0, 0);
    send(32'h00000001, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("drop_cnt_3", bus.drop_cnt, 3);
    bus.out_ready = 1'b0;
    send(32'h00000040, 32'h0, 32'hA1, 1, 32'h40, 2'b00, 5'd0);
    send(32'h00000080, 32'h0, 32'hA2, 1, 32'h80, 2'b00, 5'd0);
    bus.in_valid = 1'b1;
    bus.instr = 32'h000000C0;
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    chk("flush_full_out_valid", bus.out_valid, 0);
    chk("flush_full_in_ready", bus.in_ready, 1);
    send(32'h00000040, 32'h0, 32'hB1, 1, 32'h40, 2'b00, 5'd0);
    chk("flush_pre_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.instr = 32'h00000080;
    bus.rt_data = 32'hB2;
    flush = 1'b1;
    cyc(1);
    bus.instr = 32'h00430820;
    q.delete();
    chk("flush_acc_out_valid", bus.out_valid, 0);
    chk("flush_acc_in_ready", bus.in_ready, 1);
    cyc(1);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_drop_not_counted", bus.drop_cnt, 3);
    bus.out_ready = 1'b1;
    cyc(3);
    bus.in_valid = 1'b1;
    bus.instr = 32'h00430820;
    repeat (65532) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("drop_cnt_max", bus.drop_cnt, 16'hFFFF);
    send(32'h00430820, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("drop_cnt_sat", bus.drop_cnt, 16'hFFFF);
    bus.out_ready = 1'b0;
    send(32'h00000040, 32'h0, 32'h11, 1, 32'h40, 2'b00, 5'd0);
    send(32'h00000080, 32'h0, 32'h22, 1, 32'h80, 2'b00, 5'd0);
    bus.in_valid = 1'b1;
    bus.instr = 32'h000000C0;
    bus.rt_data = 32'h33;
    cyc(3);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_or_sh_b", bus.sh_b, 32'h40);
    bus.out_ready = 1'b1;
    send(32'h000000C0, 32'h0, 32'h33, 1, 32'hC0, 2'b00, 5'd0);
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1);
    chk("bp_drain", q.size(), 0);
    chk("bp_in_ready_back", bus.in_ready, 1);
    cyc(1);
    bus.out_ready = 1'b0;
    send(32'h00000040, 32'h0, 32'hC1, 1, 32'h40, 2'b00, 5'd0);
    send(32'h00000080, 32'h0, 32'hC2, 1, 32'h80, 2'b00, 5'd0);
    rst_n = 1'b0;
    cyc(1);
    q.delete();
    chk_reset("midrst");
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cyc(3);
    chk("final_queue", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
